age_issue_queue: RTL and testbench
==================================

Name: age_issue_queue

Overview:
- Parametrised, out-of-order issue queue with oldest-first selection through an age matrix.
- Sits between rename/dispatch and register-read/execute.
- Holds up to DEPTH micro-ops with an opaque payload and tracks source readiness from NUM_WAKE tag-broadcast ports.
- Issues one ready micro-op per cycle into a registered valid/ready output slot, and flushes selectively by ROB mask on mispredict.

Parameters:
- DEPTH, 8, queue entries (power of two, >=2)
- PREG_W, 7, physical register tag width; tag 0 is hardwired zero
- ROB_SIZE, 8, ROB entries; ROB_W = clog2(ROB_SIZE)
- NUM_FU, 8, functional-unit classes; FU_W = clog2(NUM_FU)
- NUM_WAKE, 2, wakeup broadcast ports (e.g. EX forward, WB)
- PAYLOAD_W, 128, opaque payload bits (pc/inst/imm/op/f3/f7/rd/LQ/SQ idx)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept this cycle
- disp_payload  in  PAYLOAD_W  payload
- disp_rs1 / disp_rs2  in  PREG_W each  source tags
- disp_rs1_rdy / disp_rs2_rdy  in  1 each  source ready from rename
- disp_fu_sel  in  FU_W  target FU class
- disp_rob_idx  in  ROB_W  ROB index
- wake_valid  in  NUM_WAKE  broadcast valids
- wake_tag  in  NUM_WAKE*PREG_W  broadcast tags
- fu_ready  in  NUM_FU  per-class accept
- stall  in  1  block dispatch
- flush  in  1  mispredict
- flush_mask  in  ROB_SIZE  ROB entries to kill
- iss_valid  out  1  output slot valid
- iss_ready  in  1  downstream consumes output slot
- iss_payload  out  PAYLOAD_W  payload
- iss_rs1 / iss_rs2  out  PREG_W each  source tags for register read
- iss_fu_sel  out  FU_W  FU class
- iss_rob_idx  out  ROB_W  ROB index
- occupancy  out  clog2(DEPTH)+1  valid entry count

Behaviour:
- **Reset** (rst low, async): all entry valids 0, age matrix 0, output slot invalid. iss_valid=0, occupancy=0, all iss_* data 0, disp_ready=0 while in reset.
- **disp_ready** = (any entry invalid) && !flush && !stall.
  - A slot freed by issue in the same cycle is not reusable until the next cycle.
  - A full queue therefore reports disp_ready=0 even while issuing.
- **Dispatch** fires on disp_valid && disp_ready. It writes the lowest-index invalid slot k.
  - Stored rsN_rdy = disp_rsN_rdy || (any wake_valid[w] && wake_tag[w]==disp_rsN && disp_rsN!=0).
  - A source tag of 0 is always ready.
- **Age matrix**: bit A[i][j]=1 means entry i is older than j. On dispatch into k: row k cleared; column k set to A[j][k]=valid[j] for j!=k. Only valid entries are compared.
- **Wakeup**: every cycle, each valid entry sets rsN_rdy when any wake port matches its tag (tag !=0).
- **Candidate** i: valid && eff_rs1 && eff_rs2 && fu_ready[fu_sel_i]. eff_rsN = stored rdy OR a same-cycle wake match, so downstream must forward broadcast data.
- **Select**: the candidate with no older candidate. At most one is chosen; the choice is one-hot.
- **Issue** fires when select is non-empty && (!iss_valid || iss_ready). It loads the output slot on the next edge and clears the entry; its age row and column become don't-care.
- **Output slot**:
  - Holds while iss_valid && !iss_ready.
  - Clears when iss_ready with no new issue.
  - Issue-to-output latency is 1 cycle. Throughput is 1 per cycle with no bubbles.
- **Flush**, applied when flush=1:
  - Entries with flush_mask[rob_idx]=1 are invalidated.
  - The output slot is invalidated if flush_mask[iss_rob_idx]=1.
  - No dispatch occurs (disp_ready=0).
  - An issue candidate that is itself flushed is not loaded. Surviving entries keep their age ordering.
- **Simultaneous events**:
  - Dispatch + issue + wakeup in one cycle are all legal.
  - When flush and issue coincide for the same entry, flush wins.
- **occupancy** is registered and equals the popcount of valid entries.

Optional Feature:
- Macro: AGE_ISSUE_QUEUE_PERF_EN
- When defined, adds 32-bit outputs perf_issued (count of issue fires), perf_full_cycles (cycles with all entries valid) and perf_flushed (entries killed by flush).
  - All three are saturating.
  - All three reset to 0 on reset.
- When undefined, these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package iq_pkg holds:
  - iq_entry_t (payload, rs1, rs2, rs1_rdy, rs2_rdy, fu_sel, rob_idx, valid)
  - iq_out_t
  - FU class localparams (ALU=0, MUL=1, DIV=2, FALU=3, FMUL=4, FDIV=5, LOAD=6, STORE=7)
- Sub-module iq_age_matrix(DEPTH): takes alloc one-hot, valid vector and request vector; returns a one-hot oldest grant.

Test Plan:
- Dispatch 3 ready ALU ops into empty queue, iss_ready=1 → issued in dispatch order on cycles 2, 3, 4; occupancy returns 0.
- Fill 8 entries, oldest (slot 0) waits on tag 5, others ready → slots 1..7 issue oldest-first. Wake tag 5 on port 1 → slot 0 issues next cycle. disp_ready=0 throughout the full period.
- Dispatch rs1=9 not ready while wake_tag[0]=9 in the same cycle → entry stored ready, issues the following cycle.
- iss_ready=0 for 4 cycles with 2 ready entries → output slot holds the first op stable, queue retains the second; on release they issue back-to-back.
- flush with flush_mask=8'b0000_1100 while entries hold rob 1, 2, 3 and the output slot holds rob 2 → rob 2 and 3 killed, iss_valid drops, rob 1 survives and issues; disp_ready=0 that cycle.
- Async reset asserted mid-stream with a full queue → iss_valid=0 and occupancy=0 immediately; no issue after release until a new dispatch.

Source files
------------

// File: rtl/iq_pkg.sv
// Shared types for the age-ordered issue queue: entry/output-slot records and FU class codes.
// The record field widths below must track the age_issue_queue parameter defaults.
package iq_pkg;

    localparam int IQ_PAYLOAD_W = 128;
    localparam int IQ_PREG_W    = 7;
    localparam int IQ_ROB_W     = 3;
    localparam int IQ_FU_W      = 3;

    localparam logic [IQ_FU_W-1:0] FU_ALU   = 3'd0;
    localparam logic [IQ_FU_W-1:0] FU_MUL   = 3'd1;
    localparam logic [IQ_FU_W-1:0] FU_DIV   = 3'd2;
    localparam logic [IQ_FU_W-1:0] FU_FALU  = 3'd3;
    localparam logic [IQ_FU_W-1:0] FU_FMUL  = 3'd4;
    localparam logic [IQ_FU_W-1:0] FU_FDIV  = 3'd5;
    localparam logic [IQ_FU_W-1:0] FU_LOAD  = 3'd6;
    localparam logic [IQ_FU_W-1:0] FU_STORE = 3'd7;

    typedef struct packed {
        logic [IQ_PAYLOAD_W-1:0] payload;
        logic [IQ_PREG_W-1:0]    rs1;
        logic [IQ_PREG_W-1:0]    rs2;
        logic                    rs1_rdy;
        logic                    rs2_rdy;
        logic [IQ_FU_W-1:0]      fu_sel;
        logic [IQ_ROB_W-1:0]     rob_idx;
        logic                    valid;
    } iq_entry_t;

    typedef struct packed {
        logic [IQ_PAYLOAD_W-1:0] payload;
        logic [IQ_PREG_W-1:0]    rs1;
        logic [IQ_PREG_W-1:0]    rs2;
        logic [IQ_FU_W-1:0]      fu_sel;
        logic [IQ_ROB_W-1:0]     rob_idx;
        logic                    valid;
    } iq_out_t;

endpackage

// File: rtl/iq_age_matrix.sv
// Age matrix for the issue queue: age_q[i][j]=1 means entry i is older than entry j.
// Grants the single requester that has no older requester (one-hot).
module iq_age_matrix #(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] alloc_i,
    input  logic [DEPTH-1:0] valid_i,
    input  logic [DEPTH-1:0] req_i,
    output logic [DEPTH-1:0] gnt_o
);

    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) age_d[i] = age_q[i];
        // A new entry is younger than everything currently resident.
        for (int k = 0; k < DEPTH; k++) begin
            if (alloc_i[k]) begin
                age_d[k] = '0;
                for (int j = 0; j < DEPTH; j++)
                    if (j != k) age_d[j][k] = valid_i[j];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            gnt_o[i] = req_i[i];
            for (int j = 0; j < DEPTH; j++)
                if (req_i[j] && age_q[j][i]) gnt_o[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) age_q[i] <= age_d[i];
        end
    end

endmodule

// File: rtl/age_issue_queue.sv
// Out-of-order issue queue with oldest-first select, tag wakeup, ROB-mask flush and a registered issue slot.
// Optional saturating perf counters are enabled by defining AGE_ISSUE_QUEUE_PERF_EN.
module age_issue_queue
    import iq_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PREG_W    = IQ_PREG_W,
    parameter int ROB_SIZE  = 8,
    parameter int NUM_FU    = 8,
    parameter int NUM_WAKE  = 2,
    parameter int PAYLOAD_W = IQ_PAYLOAD_W,
    localparam int ROB_W    = $clog2(ROB_SIZE),
    localparam int FU_W     = $clog2(NUM_FU),
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [PAYLOAD_W-1:0]       disp_payload,
    input  logic [PREG_W-1:0]          disp_rs1,
    input  logic [PREG_W-1:0]          disp_rs2,
    input  logic                       disp_rs1_rdy,
    input  logic                       disp_rs2_rdy,
    input  logic [FU_W-1:0]            disp_fu_sel,
    input  logic [ROB_W-1:0]           disp_rob_idx,
    input  logic [NUM_WAKE-1:0]        wake_valid,
    input  logic [NUM_WAKE*PREG_W-1:0] wake_tag,
    input  logic [NUM_FU-1:0]          fu_ready,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [ROB_SIZE-1:0]        flush_mask,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [PAYLOAD_W-1:0]       iss_payload,
    output logic [PREG_W-1:0]          iss_rs1,
    output logic [PREG_W-1:0]          iss_rs2,
    output logic [FU_W-1:0]            iss_fu_sel,
    output logic [ROB_W-1:0]           iss_rob_idx,
    output logic [CNT_W-1:0]           occupancy
`ifdef AGE_ISSUE_QUEUE_PERF_EN
    ,
    output logic [31:0]                perf_issued,
    output logic [31:0]                perf_full_cycles,
    output logic [31:0]                perf_flushed
`endif
);

    iq_entry_t        ent_q [DEPTH];
    iq_entry_t        ent_d [DEPTH];
    iq_entry_t        new_ent;
    iq_out_t          out_q, out_d;
    logic [DEPTH-1:0] vld, req, gnt, kill, free_oh, alloc;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic             disp_fire, iss_fire, out_kill;

    function automatic logic woke(input logic [PREG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int w = 0; w < NUM_WAKE; w++)
            if (wake_valid[w] && wake_tag[w*PREG_W +: PREG_W] == tag) hit = 1'b1;
        return hit && (tag != '0);
    endfunction

    always_comb begin
        free_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld[i]  = ent_q[i].valid;
            kill[i] = flush && flush_mask[ent_q[i].rob_idx];
            // Flushed entries never compete, so a surviving op can still issue this cycle.
            req[i]  = vld[i] && !kill[i]
                   && (ent_q[i].rs1_rdy || woke(ent_q[i].rs1))
                   && (ent_q[i].rs2_rdy || woke(ent_q[i].rs2))
                   && fu_ready[ent_q[i].fu_sel];
        end
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!vld[i]) begin
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
        end
    end

    assign disp_ready = rst && !(&vld) && !flush && !stall;
    assign disp_fire  = disp_valid && disp_ready;
    assign alloc      = disp_fire ? free_oh : '0;
    assign iss_fire   = (|gnt) && (!out_q.valid || iss_ready);
    assign out_kill   = out_q.valid && flush && flush_mask[out_q.rob_idx];

    iq_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk     (clk),
        .rst_n   (rst),
        .alloc_i (alloc),
        .valid_i (vld),
        .req_i   (req),
        .gnt_o   (gnt)
    );

    always_comb begin
        new_ent = '{payload: disp_payload,
                    rs1:     disp_rs1,
                    rs2:     disp_rs2,
                    rs1_rdy: disp_rs1_rdy || woke(disp_rs1) || (disp_rs1 == '0),
                    rs2_rdy: disp_rs2_rdy || woke(disp_rs2) || (disp_rs2 == '0),
                    fu_sel:  disp_fu_sel,
                    rob_idx: disp_rob_idx,
                    valid:   1'b1};
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (ent_q[i].valid) begin
                ent_d[i].rs1_rdy = ent_q[i].rs1_rdy || woke(ent_q[i].rs1);
                ent_d[i].rs2_rdy = ent_q[i].rs2_rdy || woke(ent_q[i].rs2);
            end
            if (kill[i] || (iss_fire && gnt[i])) ent_d[i].valid = 1'b0;
            if (alloc[i]) ent_d[i] = new_ent;
            occ_d = occ_d + CNT_W'(ent_d[i].valid);
        end
    end

    always_comb begin
        out_d = out_q;
        if (!iss_fire && (iss_ready || out_kill)) out_d.valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (iss_fire && gnt[i]) begin
                out_d.payload = ent_q[i].payload;
                out_d.rs1     = ent_q[i].rs1;
                out_d.rs2     = ent_q[i].rs2;
                out_d.fu_sel  = ent_q[i].fu_sel;
                out_d.rob_idx = ent_q[i].rob_idx;
                out_d.valid   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
            out_q <= '0;
            occ_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
            out_q <= out_d;
            occ_q <= occ_d;
        end
    end

    assign iss_valid   = out_q.valid;
    assign iss_payload = out_q.payload;
    assign iss_rs1     = out_q.rs1;
    assign iss_rs2     = out_q.rs2;
    assign iss_fu_sel  = out_q.fu_sel;
    assign iss_rob_idx = out_q.rob_idx;
    assign occupancy   = occ_q;

`ifdef AGE_ISSUE_QUEUE_PERF_EN
    logic [31:0]      perf_iss_q, perf_full_q, perf_fl_q;
    logic [CNT_W-1:0] n_killed;
    logic [32:0]      fl_sum;

    always_comb begin
        n_killed = '0;
        for (int i = 0; i < DEPTH; i++) n_killed = n_killed + CNT_W'(kill[i] && vld[i]);
        fl_sum = {1'b0, perf_fl_q} + 33'(n_killed);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_iss_q  <= '0;
            perf_full_q <= '0;
            perf_fl_q   <= '0;
        end else begin
            if (iss_fire && perf_iss_q != '1) perf_iss_q <= perf_iss_q + 32'd1;
            if ((&vld) && perf_full_q != '1) perf_full_q <= perf_full_q + 32'd1;
            perf_fl_q <= fl_sum[32] ? '1 : fl_sum[31:0];
        end
    end

    assign perf_issued      = perf_iss_q;
    assign perf_full_cycles = perf_full_q;
    assign perf_flushed     = perf_fl_q;
`endif

endmodule

// File: tb/tb_age_issue_queue.sv
// Randomized bench for age_issue_queue: an ordered-list reference model predicts issues into a
// scoreboard queue; a separate monitor pops and compares on every output-slot handshake.
module tb_age_issue_queue;
    import iq_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         disp_valid, disp_ready;
    logic [127:0] disp_payload;
    logic [6:0]   disp_rs1, disp_rs2;
    logic         disp_rs1_rdy, disp_rs2_rdy;
    logic [2:0]   disp_fu_sel, disp_rob_idx;
    logic [1:0]   wake_valid;
    logic [13:0]  wake_tag;
    logic [7:0]   fu_ready;
    logic         stall, flush;
    logic [7:0]   flush_mask;
    logic         iss_valid, iss_ready;
    logic [127:0] iss_payload;
    logic [6:0]   iss_rs1, iss_rs2;
    logic [2:0]   iss_fu_sel, iss_rob_idx;
    logic [3:0]   occupancy;
`ifdef AGE_ISSUE_QUEUE_PERF_EN
    logic [31:0]  perf_issued, perf_full_cycles, perf_flushed;
`endif

    always #5 clk = ~clk;

    age_issue_queue dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_payload(disp_payload),
        .disp_rs1(disp_rs1), .disp_rs2(disp_rs2),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_fu_sel(disp_fu_sel), .disp_rob_idx(disp_rob_idx),
        .wake_valid(wake_valid), .wake_tag(wake_tag), .fu_ready(fu_ready),
        .stall(stall), .flush(flush), .flush_mask(flush_mask),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_payload(iss_payload),
        .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_fu_sel(iss_fu_sel),
        .iss_rob_idx(iss_rob_idx), .occupancy(occupancy)
`ifdef AGE_ISSUE_QUEUE_PERF_EN
        , .perf_issued(perf_issued), .perf_full_cycles(perf_full_cycles), .perf_flushed(perf_flushed)
`endif
    );

    typedef struct {
        logic [127:0] pl;
        logic [6:0]   rs1, rs2;
        bit           r1, r2;
        logic [2:0]   fu, rob;
    } op_t;

    op_t        mq[$];     // resident ops, oldest first
    op_t        expq[$];   // scoreboard: ops expected out of the issue slot
    bit         sv;        // model: output slot occupied
    logic [2:0] srob;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic bit wk(input logic [6:0] t);
        return (t != 7'd0) && ((wake_valid[0] && wake_tag[6:0] == t) ||
                               (wake_valid[1] && wake_tag[13:7] == t));
    endfunction

    function automatic bit killed(input logic [2:0] rob);
        return flush && flush_mask[rob];
    endfunction

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    task automatic idle_inputs();
        disp_valid = 0; disp_payload = '0; disp_rs1 = '0; disp_rs2 = '0;
        disp_rs1_rdy = 0; disp_rs2_rdy = 0; disp_fu_sel = FU_ALU; disp_rob_idx = '0;
        wake_valid = '0; wake_tag = '0; fu_ready = '1; stall = 0; flush = 0;
        flush_mask = '0; iss_ready = 0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_iss_valid"}, iss_valid, 0);
        chk({tag, "_occupancy"}, occupancy, 0);
        chk({tag, "_disp_ready"}, disp_ready, 0);
    endtask

    // Monitor: every accepted output-slot transfer must match the oldest predicted issue.
    initial begin
        op_t e;
        forever begin
            @(negedge clk);
            if (rst && iss_valid && iss_ready && !killed(iss_rob_idx)) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL issue_unexpected got rob=%0d exp none", iss_rob_idx);
                end else begin
                    e = expq.pop_front();
                    chk("iss_payload", iss_payload, e.pl);
                    chk("iss_tags_fu_rob", {iss_rs1, iss_rs2, iss_fu_sel, iss_rob_idx},
                        {e.rs1, e.rs2, e.fu, e.rob});
                end
            end
        end
    end

    initial begin
        bit    exp_dr, issue;
        int    c, ph;
        op_t   nq[$];
        op_t   n;
        rst = 0;
        idle_inputs();
        sv = 0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks("reset");
        chk("reset_iss_data", {iss_payload, iss_rs1, iss_rs2, iss_fu_sel, iss_rob_idx}, '0);
        @(negedge clk);
        rst = 1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 1500) begin
                // Asynchronous reset mid-stream, after a fill-heavy phase.
                #2 rst = 0;
                #1 reset_checks("midreset");
                mq = {}; expq = {}; sv = 0;
                idle_inputs();
                @(negedge clk); @(negedge clk);
                rst = 1;
                continue;
            end
            ph = cyc % 300;
            disp_valid   = pct(75);
            disp_payload = {$urandom, $urandom, $urandom, $urandom};
            disp_rs1     = 7'($urandom_range(0, 7));
            disp_rs2     = 7'($urandom_range(0, 7));
            disp_rs1_rdy = pct(40);
            disp_rs2_rdy = pct(40);
            disp_fu_sel  = 3'($urandom_range(FU_ALU, FU_STORE));
            disp_rob_idx = 3'($urandom_range(0, 7));
            wake_valid   = {pct(30), pct(30)};
            wake_tag     = {7'($urandom_range(0, 7)), 7'($urandom_range(0, 7))};
            fu_ready     = (ph < 120) ? 8'($urandom & $urandom) : 8'($urandom | $urandom);
            stall        = pct(8);
            flush        = pct(4);
            flush_mask   = 8'($urandom);
            iss_ready    = (ph < 120) ? pct(15) : pct(80);

            @(negedge clk);
            exp_dr = (mq.size() < 8) && !flush && !stall;
            chk("disp_ready", disp_ready, exp_dr);
            chk("iss_valid", iss_valid, sv);
            chk("occupancy", occupancy, mq.size());

            #1;
            c = -1;
            foreach (mq[i])
                if (c < 0 && !killed(mq[i].rob) && (mq[i].r1 || wk(mq[i].rs1)) &&
                    (mq[i].r2 || wk(mq[i].rs2)) && fu_ready[mq[i].fu]) c = i;
            issue = (c >= 0) && (!sv || iss_ready);

            if (sv && killed(srob)) begin
                sv = 0;
                if (expq.size() > 0) void'(expq.pop_back());
            end else if (sv && iss_ready) begin
                sv = 0;
            end
            if (issue) begin
                sv = 1;
                srob = mq[c].rob;
                expq.push_back(mq[c]);
            end
            nq = {};
            foreach (mq[i]) begin
                if (!killed(mq[i].rob) && !(issue && i == c)) begin
                    n = mq[i];
                    n.r1 = n.r1 || wk(n.rs1);
                    n.r2 = n.r2 || wk(n.rs2);
                    nq.push_back(n);
                end
            end
            if (disp_valid && exp_dr) begin
                n.pl  = disp_payload;
                n.rs1 = disp_rs1;
                n.rs2 = disp_rs2;
                n.r1  = disp_rs1_rdy || disp_rs1 == 7'd0 || wk(disp_rs1);
                n.r2  = disp_rs2_rdy || disp_rs2 == 7'd0 || wk(disp_rs2);
                n.fu  = disp_fu_sel;
                n.rob = disp_rob_idx;
                nq.push_back(n);
            end
            mq = nq;
        end

        @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
